// File: rtl/fifo_read_ctrl_if.sv
// Read-side FIFO bus: pointer exchange with the write domain, memory read port
// and the consumer valid/ready stream.
interface fifo_read_ctrl_if #(
  parameter int N = 4
);
  logic [N:0]   wrPtrGray;
  logic [7:0]   rdData;
  logic [N-1:0] rdPtr;
  logic [N:0]   rdPtrGray;
  logic [7:0]   dOut;
  logic         dValid;
  logic         dReady;
  logic         rdEmpty;

  modport master (
    input  wrPtrGray, rdData, dReady,
    output rdPtr, rdPtrGray, dOut, dValid, rdEmpty
  );

  modport slave (
    output wrPtrGray, rdData, dReady,
    input  rdPtr, rdPtrGray, dOut, dValid, rdEmpty
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the dual-clock byte FIFO: Gray pointer exchange,
// empty detection and a 2-entry output buffer hiding the 1-cycle memory latency.
module fifo_read_ctrl #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                rdClk,
  input logic                rdRst,
  fifo_read_ctrl_if.master   rd
);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  logic [SYNC_STAGES-1:0][N:0] sync_q;
  logic [N:0]                  ptr_q, ptr_d;
  logic [N:0]                  gray_q, gray_d;
  logic                        pending_q, pending_d;
  buf_state_e                  buf_q, buf_d;
  logic [7:0]                  head_q, head_d;
  logic [7:0]                  skid_q, skid_d;

  logic [N:0] wr_sync_s;
  logic [1:0] count_s;
  logic [2:0] credit_s;
  logic       empty_s;
  logic       pop_s;
  logic       issue_s;

  assign wr_sync_s = sync_q[SYNC_STAGES-1];
  assign empty_s   = (gray_q == wr_sync_s);
  assign count_s   = buf_q;
  assign pop_s     = (buf_q != BUF_EMPTY) && rd.dReady;
  // Outstanding bytes after this cycle's pop must fit in the two buffer slots.
  assign credit_s  = {1'b0, count_s} + {2'b00, pending_q} - {2'b00, pop_s};
  assign issue_s   = !empty_s && (credit_s < 3'd2);

  assign rd.rdPtr     = ptr_q[N-1:0];
  assign rd.rdPtrGray = gray_q;
  assign rd.rdEmpty   = empty_s;
  assign rd.dOut      = head_q;
  assign rd.dValid    = (buf_q != BUF_EMPTY);

  // Read pointer advance on each issued memory read.
  always_comb begin
    ptr_d     = ptr_q;
    gray_d    = gray_q;
    pending_d = issue_s;
    if (issue_s) begin
      ptr_d  = ptr_q + (N+1)'(1);
      gray_d = ptr_d ^ (ptr_d >> 1);
    end else begin
      ptr_d  = ptr_q;
      gray_d = gray_q;
    end
  end

  // Output buffer: arriving byte goes to the tail, pop advances the head.
  always_comb begin
    buf_d  = buf_q;
    head_d = head_q;
    skid_d = skid_q;
    case (buf_q)
      BUF_EMPTY: begin
        if (pending_q) begin
          head_d = rd.rdData;
          buf_d  = BUF_ONE;
        end else begin
          buf_d  = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (pending_q && pop_s) begin
          head_d = rd.rdData;
        end else if (pending_q) begin
          skid_d = rd.rdData;
          buf_d  = BUF_TWO;
        end else if (pop_s) begin
          buf_d  = BUF_EMPTY;
        end else begin
          buf_d  = BUF_ONE;
        end
      end
      BUF_TWO: begin
        if (pop_s) begin
          head_d = skid_q;
          if (pending_q) begin
            skid_d = rd.rdData;
          end else begin
            buf_d  = BUF_ONE;
          end
        end else begin
          buf_d = BUF_TWO;
        end
      end
      default: begin
        buf_d = BUF_EMPTY;
      end
    endcase
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge rdClk) begin
    if (rdRst) begin
      sync_q    <= '0;
      ptr_q     <= '0;
      gray_q    <= '0;
      pending_q <= 1'b0;
      buf_q     <= BUF_EMPTY;
      head_q    <= 8'd0;
      skid_q    <= 8'd0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rd.wrPtrGray};
      ptr_q     <= ptr_d;
      gray_q    <= gray_d;
      pending_q <= pending_d;
      buf_q     <= buf_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a registered byte memory stands in for the
// FIFO storage and the write pointer is stepped by hand.
module tb_fifo_read_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];

  fifo_read_ctrl_if #(.N(4)) bus ();

  fifo_read_ctrl #(.N(4), .SYNC_STAGES(2)) dut (
    .rdClk (clk),
    .rdRst (rst),
    .rd    (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rdData <= mem[bus.rdPtr];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input int bin);
    bus.wrPtrGray = 5'(bin ^ (bin >> 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_wr(0);
    tick();
    rst = 1'b0;
  endtask

  // Accept bytes while dReady is high and compare against exp_q in order.
  task automatic drain(input string tag, input int budget);
    int got;
    int n;
    got = 0;
    n   = exp_q.size();
    for (int c = 0; c < budget && got < n; c++) begin
      if (bus.dValid && bus.dReady) begin
        chk(tag, {24'd0, bus.dOut}, {24'd0, exp_q[got]});
        got++;
      end
      tick();
    end
    chk({tag, "_count"}, got, n);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $error("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    bus.dReady    = 1'b0;
    bus.wrPtrGray = 5'd0;

    // 1. Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wrPtrGray = 5'($urandom);
      bus.dReady    = 1'($urandom);
      tick();
    end
    set_wr(0);
    bus.dReady = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_rdPtr",     {28'd0, bus.rdPtr},     32'd0);
    chk("rst_rdPtrGray", {27'd0, bus.rdPtrGray}, 32'd0);
    chk("rst_dValid",    {31'd0, bus.dValid},    32'd0);
    chk("rst_dOut",      {24'd0, bus.dOut},      32'd0);
    chk("rst_rdEmpty",   {31'd0, bus.rdEmpty},   32'd1);
    tick(); tick(); tick();
    chk("idle_rdPtr",    {28'd0, bus.rdPtr},     32'd0);
    chk("idle_dValid",   {31'd0, bus.dValid},    32'd0);

    // 2. Burst read of three bytes
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2;
    bus.dReady    = 1'b1;
    bus.wrPtrGray = 5'b00010;
    tick();
    chk("b_empty1",  {31'd0, bus.rdEmpty}, 32'd1);
    tick();
    chk("b_empty2",  {31'd0, bus.rdEmpty}, 32'd0);
    chk("b_valid2",  {31'd0, bus.dValid},  32'd0);
    tick();
    chk("b_valid3",  {31'd0, bus.dValid},  32'd0);
    chk("b_rdPtr3",  {28'd0, bus.rdPtr},   32'd1);
    tick();
    chk("b_valid4",  {31'd0, bus.dValid},  32'd1);
    chk("b_dout4",   {24'd0, bus.dOut},    32'hA0);
    tick();
    chk("b_dout5",   {24'd0, bus.dOut},    32'hA1);
    tick();
    chk("b_dout6",   {24'd0, bus.dOut},    32'hA2);
    tick();
    chk("b_valid7",  {31'd0, bus.dValid},    32'd0);
    chk("b_rdPtr7",  {28'd0, bus.rdPtr},     32'd3);
    chk("b_gray7",   {27'd0, bus.rdPtrGray}, 32'b00010);
    chk("b_empty7",  {31'd0, bus.rdEmpty},   32'd1);

    // 3. Backpressure with five bytes available
    bus.dReady = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem[i] = 8'hB0 + 8'(i);
      exp_q.push_back(8'hB0 + 8'(i));
    end
    set_wr(5);
    for (int i = 0; i < 8; i++) tick();
    chk("bp_rdPtr",  {28'd0, bus.rdPtr},  32'd2);
    chk("bp_valid",  {31'd0, bus.dValid}, 32'd1);
    chk("bp_dout",   {24'd0, bus.dOut},   32'hB0);
    tick(); tick(); tick();
    chk("bp_rdPtr2", {28'd0, bus.rdPtr},  32'd2);
    chk("bp_hold",   {24'd0, bus.dOut},   32'hB0);
    bus.dReady = 1'b1;
    drain("bp_data", 40);
    tick(); tick(); tick();
    chk("bp_nodup",  {31'd0, bus.dValid},  32'd0);
    chk("bp_rdPtr3", {28'd0, bus.rdPtr},   32'd5);
    chk("bp_empty",  {31'd0, bus.rdEmpty}, 32'd1);

    // 4. Wrap-around of the pointers
    do_reset();
    for (int i = 0; i < 15; i++) begin
      mem[i] = 8'h10 + 8'(i);
      exp_q.push_back(8'h10 + 8'(i));
    end
    set_wr(15);
    drain("wr_fill", 60);
    tick(); tick();
    chk("wr_rdPtr15", {28'd0, bus.rdPtr},     32'd15);
    chk("wr_gray15",  {27'd0, bus.rdPtrGray}, 32'b01000);
    mem[15] = 8'hC0;
    exp_q.push_back(8'hC0);
    set_wr(16);
    tick();
    chk("wr_rdPtr15b", {28'd0, bus.rdPtr}, 32'd15);
    drain("wr_c0", 20);
    tick(); tick();
    chk("wr_rdPtr0",  {28'd0, bus.rdPtr},     32'd0);
    chk("wr_gray16",  {27'd0, bus.rdPtrGray}, 32'b11000);
    chk("wr_empty16", {31'd0, bus.rdEmpty},   32'd1);
    mem[0] = 8'hC1;
    exp_q.push_back(8'hC1);
    set_wr(17);
    drain("wr_c1", 20);
    tick(); tick();
    chk("wr_rdPtr1",  {28'd0, bus.rdPtr},     32'd1);
    chk("wr_gray17",  {27'd0, bus.rdPtrGray}, 32'b11001);

    // 5. Reset while a byte is buffered and another is in flight
    bus.dReady = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = 8'hE0 + 8'(i);
    set_wr(5);
    tick(); tick(); tick(); tick();
    chk("mr_valid", {31'd0, bus.dValid}, 32'd1);
    chk("mr_dout",  {24'd0, bus.dOut},   32'hE0);
    chk("mr_rdPtr", {28'd0, bus.rdPtr},  32'd2);
    rst = 1'b1;
    set_wr(0);
    tick();
    rst = 1'b0;
    chk("mr_valid_rst", {31'd0, bus.dValid},    32'd0);
    chk("mr_rdPtr_rst", {28'd0, bus.rdPtr},     32'd0);
    chk("mr_gray_rst",  {27'd0, bus.rdPtrGray}, 32'd0);
    chk("mr_dout_rst",  {24'd0, bus.dOut},      32'd0);
    bus.dReady = 1'b1;
    tick(); tick(); tick(); tick();
    chk("mr_no_late", {31'd0, bus.dValid},  32'd0);
    chk("mr_empty",   {31'd0, bus.rdEmpty}, 32'd1);

    // 6. Streaming: arrival and pop every cycle
    for (int i = 0; i < 12; i++) mem[i] = 8'h50 + 8'(i);
    set_wr(12);
    begin
      int waited;
      waited = 0;
      while (!bus.dValid && waited < 20) begin
        tick();
        waited++;
      end
      chk("st_start", {31'd0, bus.dValid}, 32'd1);
    end
    for (int i = 0; i < 12; i++) begin
      chk("st_valid", {31'd0, bus.dValid}, 32'd1);
      chk("st_data",  {24'd0, bus.dOut},   {24'd0, 8'h50 + 8'(i)});
      tick();
    end
    chk("st_end_valid", {31'd0, bus.dValid},  32'd0);
    chk("st_end_rdPtr", {28'd0, bus.rdPtr},   32'd12);
    chk("st_end_empty", {31'd0, bus.rdEmpty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
